accum_ctrl: RTL
===============

// Module: accum_ctrl
// PURPOSE
//  Sequencer for one accumulator lane of the MVM datapath. Accepts a stream of
//  partial dot-product beats and tags each beat with ivalid/first/last for the
//  accumulator. Each output row is cfg_chunks beats; a job is cfg_rows rows.
//  Counts returned accumulator results, indexes them by row, and signals job completion.
// PARAMETERS
//  ROWW    8  width of cfg_rows and res_row (max 2^ROWW-1 rows per job)
//  CHUNKW  8  width of cfg_chunks (max 2^CHUNKW-1 beats per row)
//  ACC_LAT 2  accumulator latency, ivalid(last) -> ovalid; informational, not used for timing
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, synchronous, active-high
//  start       in   1       job start pulse; honoured only in IDLE
//  cfg_rows    in   ROWW    rows in job; sampled on accepted start
//  cfg_chunks  in   CHUNKW  beats per row; sampled on accepted start
//  dp_valid    in   1       upstream partial-sum beat valid
//  dp_ready    out  1       controller accepts beats (high only in RUN)
//  acc_ivalid  out  1       to accumulator ivalid
//  acc_first   out  1       to accumulator first
//  acc_last    out  1       to accumulator last
//  acc_ovalid  in   1       accumulator result valid
//  res_row     out  ROWW    row index of the result qualified by acc_ovalid
//  busy        out  1       job in progress (RUN or DRAIN)
//  done        out  1       one-cycle pulse at job completion
// BEHAVIOUR
//  Reset: state=IDLE; all counters=0; dp_ready, acc_ivalid, acc_first, acc_last,
//    busy, done=0; res_row=0. A reset mid-job aborts silently; there is no done pulse.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//   IDLE: start with cfg_rows!=0 and cfg_chunks!=0 -> latch cfg, go to RUN.
//         start with either field 0 -> go to DONE (empty job, no beats).
//   RUN: dp_ready=1. When the last beat of the last row is accepted, go to DRAIN.
//   DRAIN: dp_ready=0. When ret_cnt==rows_r, go to DONE. This can happen in the
//         same cycle as the final acc_ovalid.
//   DONE: done=1 for exactly one cycle, then go to IDLE.
//  start is ignored in RUN, DRAIN and DONE. cfg inputs are don't-care after latching.
//  Beat tagging (combinational from dp_valid, no added latency):
//   acc_ivalid = dp_valid & dp_ready
//   acc_first  = acc_ivalid & (chunk_cnt==0)
//   acc_last   = acc_ivalid & (chunk_cnt==chunks_r-1)
//   If chunks_r==1, every beat is both first and last.
//  Counters advance only on an accepted beat:
//   chunk_cnt: +1; wraps to 0 on the last beat of a row.
//   row_cnt: +1 on the last beat of a row.
//  Returns:
//   ret_cnt increments on acc_ovalid in RUN or DRAIN.
//   res_row = ret_cnt, so the first result reports 0, in the same cycle as acc_ovalid.
//   acc_ovalid in IDLE or DONE is ignored.
//  Results can overlap later input beats (pipelined). The FSM never relies on ACC_LAT;
//   completion is determined only by counting returns.
//  busy = (state==RUN) | (state==DRAIN).
//  All counter comparisons are unsigned. chunks_r-1 is computed in CHUNKW bits;
//   the zero case cannot occur because of the start check.
// STRUCTURE
//  Shared package mvm_pkg:
//   - typedef enum logic [1:0] {IDLE,RUN,DRAIN,DONE} accum_ctrl_state_t
//   - ROWW/CHUNKW default constants
//  Sub-module mod_counter (inc, clr, limit -> count, wrap), instantiated twice:
//   - chunk counter, with wrap feeding the row counter
//   - row counter
//  ret_cnt is a plain register.
//  The accumulator shares clk/rst with this block; no extra reset sequencing.
// TESTING
//  1. rows=3, chunks=4, dp_valid held high
//     -> 12 beats; first on beats 0/4/8, last on beats 3/7/11
//     -> res_row 0,1,2 with ovalid; done 1 cycle after the 3rd return.
//  2. chunks=1, rows=5
//     -> every beat has first=last=1; 5 results; done pulses once.
//  3. rows=2, chunks=3, dp_valid random 50%
//     -> first/last positions unchanged versus test 1; results at the accumulator
//        match golden sums. Example: row0=1+2+3=6, row1=-4+5+-6=-5.
//  4. start with cfg_rows=0
//     -> dp_ready stays 0; done pulses 1 cycle after start; busy never asserts.
//  5. start pulsed during RUN with different cfg
//     -> ignored; counts follow the original cfg. Back-to-back jobs: start in the
//        cycle after done -> accepted.
//  6. rst asserted after 5 beats of a rows=2, chunks=4 job
//     -> next cycle all outputs 0, state IDLE, no done. A fresh job then runs clean.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM datapath control blocks.
// Holds the accumulator-lane sequencer state encoding and default field widths.
package mvm_pkg;

    localparam int ROWW_DEF    = 8;
    localparam int CHUNKW_DEF  = 8;
    localparam int ACC_LAT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } accum_ctrl_state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts inc pulses from 0 to limit, then wraps to 0.
// wrap is combinational and flags the increment that takes count from limit back to 0.
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    assign wrap  = inc & (count_r == limit);
    assign count = count_r;

    // count register; clr has priority over inc
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            count_r <= wrap ? {W{1'b0}} : (count_r + ONE);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/accum_ctrl.sv
// Sequencer for one accumulator lane: tags incoming partial-sum beats with first/last,
// counts returned row results and pulses done once every row of the job has come back.
module accum_ctrl
    import mvm_pkg::*;
#(
    parameter int ROWW    = ROWW_DEF,
    parameter int CHUNKW  = CHUNKW_DEF,
    parameter int ACC_LAT = ACC_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROWW-1:0]   cfg_rows,
    input  logic [CHUNKW-1:0] cfg_chunks,
    input  logic              dp_valid,
    output logic              dp_ready,
    output logic              acc_ivalid,
    output logic              acc_first,
    output logic              acc_last,
    input  logic              acc_ovalid,
    output logic [ROWW-1:0]   res_row,
    output logic              busy,
    output logic              done
);

    // Completion is decided purely by counting returns, but a result must trail its last beat.
    if (ACC_LAT < 1) begin : g_acc_lat_check
        $error("accum_ctrl: ACC_LAT must be at least 1");
    end

    accum_ctrl_state_t state_r, state_s;

    logic [ROWW-1:0]   rows_r;
    logic [CHUNKW-1:0] chunks_r;
    logic [ROWW-1:0]   ret_cnt_r;

    logic [CHUNKW-1:0] chunk_cnt_s, chunk_lim_s;
    logic [ROWW-1:0]   row_cnt_s, row_lim_s;
    logic              chunk_wrap_s, row_wrap_s, job_last_s;
    logic              cnt_clr_s, start_ok_s, ret_inc_s;
    logic [ROWW:0]     ret_next_s;

    assign dp_ready   = (state_r == RUN);
    assign busy       = (state_r == RUN) | (state_r == DRAIN);
    assign done       = (state_r == DONE);
    assign res_row    = ret_cnt_r;

    assign acc_ivalid = dp_valid & dp_ready;
    assign acc_first  = acc_ivalid & (chunk_cnt_s == {CHUNKW{1'b0}});
    assign acc_last   = chunk_wrap_s;

    assign chunk_lim_s = chunks_r - {{(CHUNKW-1){1'b0}}, 1'b1};
    assign row_lim_s   = rows_r - {{(ROWW-1){1'b0}}, 1'b1};
    assign cnt_clr_s   = (state_r == IDLE);
    assign start_ok_s  = (cfg_rows != {ROWW{1'b0}}) & (cfg_chunks != {CHUNKW{1'b0}});
    assign job_last_s  = row_wrap_s & (row_cnt_s == row_lim_s);

    assign ret_inc_s  = acc_ovalid & busy;
    assign ret_next_s = {1'b0, ret_cnt_r} + {{ROWW{1'b0}}, ret_inc_s};

    mod_counter #(.W(CHUNKW)) u_chunk_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (acc_ivalid),
        .clr   (cnt_clr_s),
        .limit (chunk_lim_s),
        .count (chunk_cnt_s),
        .wrap  (chunk_wrap_s)
    );

    mod_counter #(.W(ROWW)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (chunk_wrap_s),
        .clr   (cnt_clr_s),
        .limit (row_lim_s),
        .count (row_cnt_s),
        .wrap  (row_wrap_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // job configuration, captured only when IDLE accepts a start
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_r   <= {ROWW{1'b0}};
            chunks_r <= {CHUNKW{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            rows_r   <= cfg_rows;
            chunks_r <= cfg_chunks;
        end else begin
            rows_r   <= rows_r;
            chunks_r <= chunks_r;
        end
    end

    // returned-result counter, reused as the row index of the current result
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_cnt_r <= {ROWW{1'b0}};
        end else if (state_r == IDLE) begin
            ret_cnt_r <= {ROWW{1'b0}};
        end else if (ret_inc_s) begin
            ret_cnt_r <= ret_next_s[ROWW-1:0];
        end else begin
            ret_cnt_r <= ret_cnt_r;
        end
    end

    // next-state logic; DRAIN looks at the post-increment count so done follows the final return by one cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = start_ok_s ? RUN : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (job_last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (ret_next_s == {1'b0, rows_r}) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

endmodule
